alu_share_sched: RTL and testbench
==================================

# alu_share_sched

Scheduler that shares one combinational N-bit ALU (ADD/SUB/XOR/NOT, 2-bit control) between two requesters. Each requester has its own valid/ready request channel and response channel. The block arbitrates round-robin, registers the winner's operands, drives the shared ALU for one cycle, and returns a registered result plus carry. It sits between the two datapath clients and the single ALU instance, which is connected through the `alu_*` ports.

## Interface
- N, 4, operand/result width; must match the attached ALU.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: the operation of requester i is accepted this cycle.
- req0_a, req0_b  in  N  operands of requester 0.
- req1_a, req1_b  in  N  operands of requester 1.
- req0_op, req1_op  in  2  ALU control: 00 ADD, 01 SUB, 10 XOR, 11 NOT(B).
- rsp_valid  out  2  bit i: a result for requester i is available.
- rsp_ready  in  2  bit i: requester i consumes the result.
- rsp_data  out  N  result, shared by both requesters; qualified by rsp_valid.
- rsp_cout  out  1  carry/no-borrow, shared; qualified by rsp_valid.
- alu_a, alu_b  out  N  operands to the shared ALU.
- alu_ctrl  out  2  control to the shared ALU.
- alu_out  in  N  ALU result (combinational from alu_*).
- alu_cout  in  1  ALU carry-out.

## Operation
- FSM states are IDLE, ISSUE and RESP. On reset the FSM enters IDLE.
- IDLE:
  - If any req_valid bit is set, select a winner, pulse req_ready[winner] for exactly that cycle, and latch a/b/op and the winner index.
  - Next state is ISSUE.
  - If no req_valid bit is set, stay in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that was not the last grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates on every accept.
- ISSUE:
  - alu_a/alu_b/alu_ctrl are driven from the latched registers.
  - alu_out is captured into rsp_data.
  - For op 00/01, alu_cout is captured into rsp_cout. For op 10/11, rsp_cout is forced to 0.
  - Next state is RESP.
- RESP:
  - rsp_valid[winner] is held at 1. The other rsp_valid bit stays 0.
  - rsp_data and rsp_cout are held stable.
  - On rsp_ready[winner]=1, go to IDLE. rsp_ready of the non-winner is ignored.
- No new request is accepted outside IDLE; req_ready is 0 in ISSUE and RESP.
- Outside ISSUE, alu_a, alu_b and alu_ctrl are driven to 0.
- SUB semantics: result = A + ~B + 1 mod 2^N. cout=1 means no borrow (A ≥ B unsigned).
- All arithmetic wraps modulo 2^N. There is no overflow flag.

## Timing
- Reset values: req_ready=00, rsp_valid=00, rsp_data=0, rsp_cout=0, alu_a=0, alu_b=0, alu_ctrl=00, last_grant=1, state IDLE.
- Accept happens at cycle T (req_valid & req_ready). rsp_valid rises at T+2. Fixed latency is 2 cycles.
- Response with rsp_ready already high: rsp_valid is high for one cycle (T+2). The next accept is possible at T+3, giving a minimum issue interval of 3 cycles.
- Backpressure: RESP holds for any number of cycles, and data stays stable while rsp_valid=1 and rsp_ready=0.
- Requesters must hold valid and operands until ready. A requester that drops valid before being granted is simply not served.
- A losing requester remains pending and wins the next IDLE cycle if it is still valid. This guarantees no starvation.
- Reset asserted mid-operation (ISSUE or RESP): all outputs clear immediately (asynchronous). The in-flight result is lost, and no response is issued after reset.
- Simultaneous rsp_ready and a new req_valid in RESP: return to IDLE first. The new request is accepted one cycle later.

## Test plan
- Reset check:
  - Stimulus: assert rst mid-RESP.
  - Required: rsp_valid=00, req_ready=00, alu_ctrl=00 at once; after release, the first tie grants requester 0.
- Single ADD and wrap, N=4:
  - Stimulus: req0 5+4 (op 00). Required: rsp_data=9, cout=0 at T+2.
  - Stimulus: req0 9+8. Required: rsp_data=1, cout=1.
- SUB borrow:
  - Stimulus: req1 3−5 (op 01). Required: rsp_data=E, cout=0.
  - Stimulus: req1 5−3. Required: rsp_data=2, cout=1.
- XOR/NOT:
  - Stimulus: req0 A=C, B=A, op 10. Required: rsp_data=6, cout=0.
  - Stimulus: op 11, B=3. Required: rsp_data=C, cout=0.
- Round-robin fairness:
  - Stimulus: both requesters continuously valid for 6 ops.
  - Required: grants alternate 0,1,0,1,0,1; each rsp_valid goes only to its own requester.
- Backpressure:
  - Stimulus: hold rsp_ready[0]=0 for 5 cycles while req1 is valid.
  - Required: rsp_data stays stable and req_ready stays 00; req1 is accepted in the cycle after rsp_ready[0] rises.

Source files
------------

// File: rtl/alu_share_sched.sv
// ==== alu_share_sched : round-robin scheduler sharing one ALU between two requesters (rev 1.0) ====
`default_nettype none

module alu_share_sched #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    input  logic [1:0]   req0_op_i,
    input  logic [1:0]   req1_op_i,
    output logic [1:0]   rsp_valid_o,
    input  logic [1:0]   rsp_ready_i,
    output logic [N-1:0] rsp_data_o,
    output logic         rsp_cout_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [1:0]   alu_ctrl_o,
    input  logic [N-1:0] alu_out_i,
    input  logic         alu_cout_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t       state_q;
    logic         win_q;
    logic         last_grant_q;
    logic [1:0]   rsp_valid_q;
    logic [N-1:0] rsp_data_q;
    logic         rsp_cout_q;
    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [1:0]   alu_ctrl_q;

    logic         win_d;
    logic [1:0]   grant_d;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        case (req_valid_i)
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = ~last_grant_q;
            default: win_d = 1'b0;
        endcase
        grant_d = 2'b00;
        if (state_q == S_IDLE && !rst && req_valid_i != 2'b00) begin
            grant_d = win_d ? 2'b10 : 2'b01;
        end
    end

    // The alu_* registers hold the latched operands only while in ISSUE, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i != 2'b00) begin
                        win_q        <= win_d;
                        last_grant_q <= win_d;
                        alu_a_q      <= win_d ? req1_a_i  : req0_a_i;
                        alu_b_q      <= win_d ? req1_b_i  : req0_b_i;
                        alu_ctrl_q   <= win_d ? req1_op_i : req0_op_i;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_data_q  <= alu_out_i;
                    rsp_cout_q  <= alu_ctrl_q[1] ? 1'b0 : alu_cout_i;
                    rsp_valid_q <= win_q ? 2'b10 : 2'b01;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    alu_ctrl_q  <= 2'b00;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i[win_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = grant_d;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_ctrl_o  = alu_ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_sched.sv
// ==== tb_alu_share_sched : randomized and directed checks of alu_share_sched against a transaction model (rev 1.0) ====
`default_nettype none

module tb_alu_share_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] ra [2];
    logic [N-1:0] rb [2];
    logic [1:0]   rop [2];
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_cout;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic         alu_cout;
    logic [N:0]   alu_sum;

    int n_vec = 0;
    int n_err = 0;

    alu_share_sched #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req0_a_i   (ra[0]),
        .req0_b_i   (rb[0]),
        .req1_a_i   (ra[1]),
        .req1_b_i   (rb[1]),
        .req0_op_i  (rop[0]),
        .req1_op_i  (rop[1]),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_cout_o (rsp_cout),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_ctrl_o (alu_ctrl),
        .alu_out_i  (alu_out),
        .alu_cout_i (alu_cout)
    );

    always #5 clk = ~clk;

    // Attached ALU; carry-out is deliberately 1 for the logic ops.
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            2'b10:   alu_sum = {1'b1, alu_a ^ alu_b};
            default: alu_sum = {1'b1, ~alu_b};
        endcase
        alu_out  = alu_sum[N-1:0];
        alu_cout = alu_sum[N];
    end

    // Transaction model: one operation in flight, aged in cycles since its accept.
    logic       m_busy;
    int         m_age;
    logic       m_win;
    logic       m_last;
    logic [N-1:0] m_a, m_b;
    logic [1:0] m_op;
    logic [N:0] m_res;

    logic [1:0]   acc, obs_rv, obs_ready;
    logic [N-1:0] obs_data;
    logic         obs_cout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        return !last;
    endfunction

    function automatic logic [N:0] exp_res(input int a, input int b, input int op);
        int m;
        int d;
        int c;
        m = 1 << N;
        case (op)
            0:       begin d = (a + b) % m;     c = (a + b >= m) ? 1 : 0; end
            1:       begin d = (a - b + m) % m; c = (a >= b) ? 1 : 0;     end
            2:       begin d = a ^ b;           c = 0;                     end
            default: begin d = (m - 1) - b;     c = 0;                     end
        endcase
        return {c[0], d[N-1:0]};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_win  = 1'b0;
        m_last = 1'b1;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, returns at next posedge+1.
    task automatic cycle();
        logic [1:0] er;
        logic       in_issue, in_resp;
        @(negedge clk);
        er = 2'b00;
        if (!m_busy && req_valid != 2'b00) er = pick(req_valid, m_last) ? 2'b10 : 2'b01;
        in_issue = m_busy && m_age == 1;
        in_resp  = m_busy && m_age >= 2;
        chk("req_ready", req_ready, er);
        chk("alu_a", alu_a, in_issue ? m_a : 4'd0);
        chk("alu_b", alu_b, in_issue ? m_b : 4'd0);
        chk("alu_ctrl", alu_ctrl, in_issue ? m_op : 2'd0);
        chk("rsp_valid", rsp_valid, in_resp ? (m_win ? 2'b10 : 2'b01) : 2'b00);
        if (in_resp) begin
            chk("rsp_data", rsp_data, m_res[N-1:0]);
            chk("rsp_cout", rsp_cout, m_res[N]);
        end
        acc       = req_valid & req_ready;
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_data  = rsp_data;
        obs_cout  = rsp_cout;
        if (m_busy) begin
            if (in_resp && rsp_ready[m_win]) m_busy = 1'b0;
            else m_age++;
        end else if (er != 2'b00) begin
            m_win  = er[1];
            m_last = er[1];
            m_a    = ra[er[1]];
            m_b    = rb[er[1]];
            m_op   = rop[er[1]];
            m_res  = exp_res(int'(m_a), int'(m_b), int'(m_op));
            m_busy = 1'b1;
            m_age  = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int i);
        ra[i]  = 4'($urandom);
        rb[i]  = 4'($urandom);
        rop[i] = 2'($urandom);
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic directed(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [1:0] op, input logic [N-1:0] ed, input logic ec);
        logic seen;
        seen = 1'b0;
        ra[id] = a; rb[id] = b; rop[id] = op;
        req_valid[id] = 1'b1;
        rsp_ready = 2'b11;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (acc[id]) req_valid[id] = 1'b0;
            if (obs_rv[id]) seen = 1'b1;
        end
        chk("dir_seen", seen, 1'b1);
        chk("dir_data", obs_data, ed);
        chk("dir_cout", obs_cout, ec);
        drain();
    endtask

    initial begin
        int grants[6];
        int n;
        logic [N-1:0] d0;
        logic seen;

        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        rand_ops(0);
        rand_ops(1);
        model_reset();
        #3;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 4'd0);
        chk("rst_rsp_cout", rsp_cout, 1'b0);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_alu_b", alu_b, 4'd0);
        chk("rst_alu_ctrl", alu_ctrl, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with both requesters continuously valid.
        foreach (grants[k]) grants[k] = 9;
        n = 0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 60 && n < 6; k++) begin
            cycle();
            if (acc == 2'b01) begin grants[n] = 0; n++; rand_ops(0); end
            if (acc == 2'b10) begin grants[n] = 1; n++; rand_ops(1); end
        end
        chk("rr_count", n, 6);
        for (int k = 0; k < 6; k++) chk("rr_grant", grants[k], k % 2);
        drain();

        directed(0, 4'd5, 4'd4, 2'b00, 4'd9, 1'b0);
        directed(0, 4'd9, 4'd8, 2'b00, 4'd1, 1'b1);
        directed(1, 4'd3, 4'd5, 2'b01, 4'hE, 1'b0);
        directed(1, 4'd5, 4'd3, 2'b01, 4'd2, 1'b1);
        directed(0, 4'hC, 4'hA, 2'b10, 4'd6, 1'b0);
        directed(0, 4'd0, 4'd3, 2'b11, 4'hC, 1'b0);

        // Backpressure on requester 0 while requester 1 waits.
        ra[0] = 4'd7; rb[0] = 4'd2; rop[0] = 2'b00;
        rand_ops(1);
        req_valid = 2'b01;
        rsp_ready = 2'b10;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (acc[0]) req_valid = 2'b10;
            if (obs_rv[0]) seen = 1'b1;
        end
        chk("bp_seen", seen, 1'b1);
        d0 = obs_data;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_data", obs_data, d0);
            chk("bp_ready", obs_ready, 2'b00);
        end
        rsp_ready = 2'b01;
        cycle();
        chk("bp_release_ready", obs_ready, 2'b00);
        cycle();
        chk("bp_accept", acc, 2'b10);
        drain();

        // Reset asserted while a response for requester 0 is pending.
        rand_ops(0);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (acc[0]) req_valid = 2'b00;
            if (obs_rv[0]) seen = 1'b1;
        end
        chk("mid_seen", seen, 1'b1);
        req_valid = 2'b10;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
        chk("mid_rst_req_ready", req_ready, 2'b00);
        chk("mid_rst_alu_ctrl", alu_ctrl, 2'b00);
        chk("mid_rst_rsp_data", rsp_data, 4'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_ops(0);
        rand_ops(1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        cycle();
        chk("rst_tie", acc, 2'b01);
        drain();

        // Randomized traffic; requesters hold valid until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    rand_ops(i);
                end
            end
            rsp_ready = 2'($urandom);
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'($urandom);
                    rand_ops(i);
                end
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
